mult_share_arb: RTL and testbench

// - Shares one DW x DW multiplier (product truncated to DW bits, modulo 2^DW)

---
 rtl/mult_share_arb_if.sv | 26 ++
 rtl/mult_share_arb.sv | 112 +++++++++++
 tb/tb_mult_share_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_share_arb_if.sv
// rtl/mult_share_arb_if.sv - request/result bus of the shared multiplier arbiter
// Requesters and the result consumer sit on the master side; the arbiter is the slave.
interface mult_share_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [IDW-1:0]     res_id;
  logic [DW-1:0]      res_p;

  modport slave (
    input  req_valid, req_x, req_y, res_ready,
    output req_ready, res_valid, res_id, res_p
  );

  modport master (
    output req_valid, req_x, req_y, res_ready,
    input  req_ready, res_valid, res_id, res_p
  );
endinterface

// File: rtl/mult_share_arb.sv
// rtl/mult_share_arb.sv - round-robin arbiter sharing one DW x DW truncating multiplier
// Define MULT_SHARE_ARB_PIPE_EN to split CALC into an operand stage and a product stage.
module mult_share_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_share_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  win_id;
  logic            win_found;
  logic [NREQ-1:0] win_onehot;
  logic [DW-1:0]   x_q, y_q;
  logic [IDW-1:0]  res_id_q;
  logic [DW-1:0]   res_p_q;
  logic            accept;
  logic            calc_done;

  // Circular search starting at ptr; the first valid requester wins.
  always_comb begin
    int idx;
    win_found  = 1'b0;
    win_id     = '0;
    win_onehot = '0;
    idx        = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
    win_onehot[win_id] = win_found;
  end

  assign bus.req_ready = (rst_n && state == IDLE) ? win_onehot : '0;
  assign accept        = (state == IDLE) && win_found;

`ifdef MULT_SHARE_ARB_PIPE_EN
  logic          calc_ph;
  logic [DW-1:0] prod_q;
  assign calc_done = calc_ph;
`else
  assign calc_done = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = HOLD;
      HOLD:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      res_id_q <= '0;
    end else if (accept) begin
      x_q      <= bus.req_x[win_id*DW +: DW];
      y_q      <= bus.req_y[win_id*DW +: DW];
      res_id_q <= win_id;
      ptr      <= (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
    end
  end

  // Assigning the DW x DW product to a DW-bit register keeps only the low half.
`ifdef MULT_SHARE_ARB_PIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_ph <= 1'b0;
      prod_q  <= '0;
      res_p_q <= '0;
    end else if (state == CALC) begin
      calc_ph <= ~calc_ph;
      if (!calc_ph) prod_q  <= x_q * y_q;
      else          res_p_q <= prod_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             res_p_q <= '0;
    else if (state == CALC) res_p_q <= x_q * y_q;
  end
`endif

  assign bus.res_valid = (state == HOLD);
  assign bus.res_id    = res_id_q;
  assign bus.res_p     = res_p_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// tb/tb_mult_share_arb.sv - randomized self-checking bench for mult_share_arb
// Reference model: circular first-valid grant from a model pointer, product = (x*y) % 256.
module tb_mult_share_arb;
  localparam int NREQ = 4;
  localparam int DW   = 8;
`ifdef MULT_SHARE_ARB_PIPE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult_share_arb_if #(.NREQ(NREQ), .DW(DW)) bus ();

  mult_share_arb #(.NREQ(NREQ), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic int model_grant(input logic [3:0] mask);
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (m_ptr + i) % NREQ;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    m_ptr = 0;
    step();
  endtask

  // One complete transaction from IDLE; returns the grant vector seen.
  task automatic run_txn(input logic [3:0] mask, input logic [31:0] xs, input logic [31:0] ys,
                         input int stall, input bit keep_valid, output logic [3:0] seen);
    int g, cyc, xv, yv;
    logic [3:0] exp_oh;
    logic [7:0] ep;
    bus.req_valid = mask;
    bus.req_x     = xs;
    bus.req_y     = ys;
    bus.res_ready = 1'b0;
    #1;
    g = model_grant(mask);
    exp_oh = '0;
    exp_oh[g] = 1'b1;
    seen = bus.req_ready;
    checks++;
    if (bus.req_ready !== exp_oh) begin
      failures++;
      $display("FAIL grant: got %b want %b", bus.req_ready, exp_oh);
    end
    xv = int'(xs[g*8 +: 8]);
    yv = int'(ys[g*8 +: 8]);
    ep = 8'((xv * yv) % 256);
    m_ptr = (g + 1) % NREQ;
    step();
    if (!keep_valid) bus.req_valid = '0;
    bus.req_x = {$urandom};
    bus.req_y = {$urandom};
    #1;
    cyc = 1;
    while (bus.res_valid !== 1'b1 && cyc < 8) begin
      checks++;
      if (bus.req_ready !== 4'b0) begin
        failures++;
        $display("FAIL calc_ready: got %b want 0000", bus.req_ready);
      end
      step();
      cyc++;
    end
    checks++;
    if (cyc != LAT) begin
      failures++;
      $display("FAIL latency: got %0d want %0d", cyc, LAT);
    end
    checks++;
    if (bus.res_p !== ep || bus.res_id !== 2'(g)) begin
      failures++;
      $display("FAIL result: got p=%0d id=%0d want p=%0d id=%0d", bus.res_p, bus.res_id, ep, g);
    end
    for (int s = 0; s < stall; s++) begin
      step();
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_p !== ep || bus.res_id !== 2'(g) || bus.req_ready !== 4'b0) begin
        failures++;
        $display("FAIL hold: got v=%b p=%0d id=%0d rdy=%b want v=1 p=%0d id=%0d rdy=0000",
                 bus.res_valid, bus.res_p, bus.res_id, bus.req_ready, ep, g);
      end
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    #1;
    checks++;
    if (bus.res_valid !== 1'b0) begin
      failures++;
      $display("FAIL release: got res_valid=%b want 0", bus.res_valid);
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.req_ready !== 4'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (bus.req_ready !== 4'b0 || bus.res_valid !== 1'b0 || bus.res_p !== 8'd0 || bus.res_id !== 2'd0) begin
        failures++;
        $display("FAIL idle: got rdy=%b v=%b p=%0d id=%0d want 0000 0 0 0",
                 bus.req_ready, bus.res_valid, bus.res_p, bus.res_id);
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] seen;
    run_txn(4'b0001, 32'd12, 32'd10, 0, 1'b0, seen);
  endtask

  task automatic test_truncation();
    logic [3:0] seen;
    run_txn(4'b0001, 32'd255, 32'd255, 0, 1'b0, seen);
    run_txn(4'b0001, 32'd16, 32'd16, 0, 1'b0, seen);
  endtask

  task automatic test_round_robin();
    logic [3:0] seen, want;
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      run_txn(4'hF, {$urandom}, {$urandom}, 0, 1'b1, seen);
      want = '0;
      want[k % NREQ] = 1'b1;
      checks++;
      if (seen !== want) begin
        failures++;
        $display("FAIL rr_order: step %0d got %b want %b", k, seen, want);
      end
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] seen;
    run_txn(4'b0100, 32'd3 << 16, 32'd7 << 16, 5, 1'b1, seen);
    bus.req_valid = '0;
  endtask

  task automatic test_mid_reset();
    logic [3:0] seen;
    apply_reset();
    bus.req_valid = 4'b0100;
    bus.req_x = 32'd9 << 16;
    bus.req_y = 32'd9 << 16;
    #1;
    step();
    bus.req_valid = 4'hF;
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0) begin
        failures++;
        $display("FAIL mid_reset: got v=%b rdy=%b want 0 0000", bus.res_valid, bus.req_ready);
      end
      step();
    end
    bus.req_valid = '0;
    rst_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (bus.res_valid !== 1'b0) begin
        failures++;
        $display("FAIL post_reset: got res_valid=%b want 0", bus.res_valid);
      end
    end
    run_txn(4'b1010, {$urandom}, {$urandom}, 0, 1'b0, seen);
    checks++;
    if (seen !== 4'b0010) begin
      failures++;
      $display("FAIL ptr_reset: got %b want 0010", seen);
    end
  endtask

  task automatic test_random();
    logic [3:0] seen;
    for (int k = 0; k < 24; k++) begin
      run_txn(4'($urandom_range(1, 15)), {$urandom}, {$urandom},
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), seen);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_single();
    test_truncation();
    test_round_robin();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
